// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch: drives PC to imem, captures the word RD_LAT edges later, presents it to decode with valid/ready.
// Redirect preempts any in-flight fetch; `define FETCH_HALT_EN to stop fetching on an all-zero word.
module instr_fetch_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startPC,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID, HALT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ipc_q, ipc_d;
  logic        zero_word;

  always_comb begin
`ifdef FETCH_HALT_EN
    zero_word = (imem_data == 32'h0000_0000);
`else
    zero_word = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      pc_q    <= 64'd0;
      cnt_q   <= 4'd0;
      instr_q <= 32'd0;
      ipc_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // Redirect outranks every transition except the absorbing HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = WAIT;
      WAIT: begin
        if (redirect)             state_d = WAIT;
        else if (cnt_q == 4'd0)   state_d = zero_word ? HALT : VALID;
      end
      VALID: begin
        if (redirect || instr_ready) state_d = WAIT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (state_q != HALT && redirect) begin
      pc_d  = redirect_pc & ~64'h3;
      cnt_d = LAT_M1;
    end else begin
      case (state_q)
        IDLE: begin
          pc_d  = startPC;
          cnt_d = LAT_M1;
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            instr_d = imem_data;
            ipc_d   = pc_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc_d  = pc_q + 64'd4;
            cnt_d = LAT_M1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_pc    = ipc_q;
    instr_valid = (state_q == VALID);
`ifdef FETCH_HALT_EN
    halted      = (state_q == HALT);
`else
    halted      = 1'b0;
`endif
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: instruction-memory read latency in clock cycles, legal range 1..15.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port resetl, input, 1: asynchronous reset, active-low.
REQ-004 SHALL have port startPC, input, 64: first fetch address, sampled when leaving IDLE.
REQ-005 SHALL have port imem_addr, output, 64: address to instruction memory; combinationally equal to the PC register.
REQ-006 SHALL have port imem_data, input, 32: instruction word returned by instruction memory.
REQ-007 SHALL have port instr, output, 32: captured instruction, registered.
REQ-008 SHALL have port instr_pc, output, 64: address of instr, registered.
REQ-009 SHALL have port instr_valid, output, 1: instr/instr_pc hold a valid fetch.
REQ-010 SHALL have port instr_ready, input, 1: decode accepts; a transfer occurs on an edge where instr_valid and instr_ready are both 1.
REQ-011 SHALL have port redirect, input, 1: branch/jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 64: redirect target.
REQ-013 SHALL have port halted, output, 1: fetch stopped on a zero word.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, VALID, HALT, plus a 4-bit latency counter.
REQ-015 IDLE: next edge loads PC <= startPC, counter <= RD_LAT-1, goes to WAIT.
REQ-016 WAIT: counter decrements each edge; on the edge where counter==0, captures instr <= imem_data and instr_pc <= PC, sets instr_valid, and goes to VALID.
REQ-017 VALID: instr, instr_pc and instr_valid are held stable while instr_ready is 0; on transfer, PC <= PC+4, counter <= RD_LAT-1, instr_valid <= 0, and goes to WAIT.
REQ-018 PC arithmetic SHALL be modulo 2^64: PC 0xFFFF_FFFF_FFFF_FFFC increments to 0.
REQ-019 redirect in IDLE, WAIT or VALID SHALL have priority over every other transition: PC <= {redirect_pc[63:2],2'b00}, counter <= RD_LAT-1, instr_valid <= 0, next state WAIT; an in-flight WAIT fetch is discarded.
REQ-020 redirect and a transfer on the same edge: the transfer counts as completed and the next fetch is from the redirect target; no fetch from PC+4 occurs.
REQ-021 redirect in IDLE: the redirect target replaces startPC.
REQ-022 Steady-state throughput SHALL be one instruction per RD_LAT+1 cycles with instr_ready held at 1; the first instr_valid rises RD_LAT+1 edges after resetl deasserts.
REQ-023 HALT: absorbing state; redirect and instr_ready are ignored; only reset exits it.

Reset
REQ-024 resetl=0 SHALL immediately force: state IDLE, PC 0, counter 0, instr 0, instr_pc 0, instr_valid 0, halted 0.
REQ-025 Reset asserted mid-fetch or mid-handshake SHALL abort that fetch with no transfer; operation resumes from IDLE using startPC.

Configuration
REQ-026 Macro FETCH_HALT_EN defined: a captured imem_data of 32'h00000000 SHALL make the FSM go to HALT instead of VALID, set halted=1, and keep instr_valid=0; instr and instr_pc still capture the zero word and its address.
REQ-027 Macro FETCH_HALT_EN undefined: a zero word SHALL be delivered as a normal instruction, halted SHALL be tied to 0, and HALT SHALL be unreachable.

Verification (RD_LAT=2, startPC=0, memory 0x0..0x10 = 32'h8b020020, all other addresses = 0)
REQ-028 Reset release with instr_ready=1 -> instr_valid rises 3 edges later, instr=8b020020, instr_pc=0; the next valid is 3 edges later with instr_pc=4.
REQ-029 instr_ready=0 for 10 cycles at instr_pc=8 -> instr and instr_pc are held stable, imem_addr=8 throughout; after ready rises, the next instr_pc is 0xC.
REQ-030 redirect=1, redirect_pc=0x13 during WAIT -> imem_addr=0x10 on the next cycle, the discarded fetch is never presented, the next instr_pc is 0x10.
REQ-031 FETCH_HALT_EN defined, free-run -> five transfers (0x0..0x10), then a fetch at 0x14 gives halted=1 and instr_valid stays 0; a redirect to 0 is ignored. Undefined -> a sixth transfer of 32'h0 at 0x14 occurs.
REQ-032 resetl pulsed low while VALID with instr_ready=0 -> all outputs clear asynchronously; no transfer is recorded; refetch starts from startPC.
REQ-033 redirect_pc=0xFFFF_FFFF_FFFF_FFFC, then free-run -> the next instr_pc after that address is 0 (wrap-around).
